// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserializer (start/data/[parity]/stop framing, 1-cycle strobes)
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t            state_q, state_d;
  logic              rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic              valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, pbad_q, pbad_d, busy_q, busy_d;
  logic              at_last;
  // Framing state machine: next state, sampling, shifting and strobes.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    at_last   = cnt_q == LAST;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    data_d    = data_q;
    pbad_d    = pbad_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        bit_d  = '0;
        pbad_d = 1'b0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (cnt_q == HALF) state_d = rx_s_q ? IDLE : DATA;
      DATA: if (at_last) begin
        shift_d = DATA_W'({rx_s_q, shift_q} >> 1);
        bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == BLAST) state_d = PARITY;
`else
        if (bit_q == BLAST) state_d = STOP;
`endif
      end
      PARITY: if (at_last) begin
        pbad_d  = ^shift_q ^ rx_s_q;
        state_d = STOP;
      end
      STOP: if (at_last) begin
        ferr_d  = !rx_s_q;
        perr_d  = rx_s_q && pbad_q;
        valid_d = rx_s_q && !pbad_q;
        data_d  = valid_d ? shift_q : data_q;
        state_d = rx_s_q ? IDLE : BREAK;
      end
      BREAK: state_d = rx_s_q ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    cnt_d  = (state_d != state_q || at_last) ? '0 : cnt_q + 1'b1;
    busy_d = state_q != IDLE;
  end
  // State, synchronizer and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      pbad_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      pbad_q    <= pbad_d;
      busy_q    <= busy_d;
    end
  end
  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: randomized self-checking bench for uart_rx_deser against a frame-level model
module tb_uart_rx_deser;
  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT   = CPB / 2 + (DW + 1) * CPB + 1 + 2 + PB * CPB;
  localparam int FRAME = (DW + 2 + PB) * CPB;
  localparam int K_VALID = 0, K_FERR = 1, K_PERR = 2;
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic [DW-1:0] rx_data;
  logic rx_valid, frame_err, parity_err, busy;
  uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {int c; int k; logic [7:0] d;} ev_t;
  ev_t  evq[$];
  logic busy_at[int];
  int   cyc = 0, n_cmp = 0, n_bad = 0, t0;
  logic [7:0] last_good = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  // Record every strobe and the busy level, sampled mid-cycle.
  always @(negedge clk) begin
    busy_at[cyc] = busy;
    if (rx_valid) evq.push_back('{c: cyc, k: K_VALID, d: rx_data});
    if (frame_err) evq.push_back('{c: cyc, k: K_FERR, d: rx_data});
    if (parity_err) evq.push_back('{c: cyc, k: K_PERR, d: rx_data});
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  // Outcome of a frame from its bits: stop low wins, then parity, else good word.
  function automatic int model_kind(input logic [7:0] d, input logic p, input logic s);
    if (!s) return K_FERR;
    if (PB == 1 && (^d ^ p)) return K_PERR;
    return K_VALID;
  endfunction
  function automatic ev_t pop_ev();
    ev_t e = '{c: -1, k: -1, d: 8'h00};
    if (evq.size() > 0) e = evq.pop_front();
    return e;
  endfunction
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0;
    t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PB == 1) begin
      rx = p;
      repeat (CPB) @(negedge clk);
    end
    rx = s;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, parity_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b busy=%b, required all 0",
               rx_data, rx_valid, frame_err, parity_err, busy);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_basic();
    ev_t e;
    evq.delete();
    send_frame(8'hA5, ^8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    e = pop_ev();
    n_cmp++;
    if (e.k !== K_VALID || e.d !== 8'hA5 || e.c - t0 !== LAT) begin
      n_bad++;
      $display("FAIL basic_a5: got kind=%0d data=%h lat=%0d, required kind=0 data=a5 lat=%0d", e.k, e.d, e.c - t0, LAT);
    end
    n_cmp++;
    if (busy_at[e.c] !== 1'b1 || busy_at[e.c + 1] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy: got busy %b then %b at strobe, required 1 then 0", busy_at[e.c], busy_at[e.c + 1]);
    end
    n_cmp++;
    if (evq.size() !== 0 || rx_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL basic_single: got extra=%0d data=%h, required extra=0 data=a5", evq.size(), rx_data);
    end
    last_good = 8'hA5;
  endtask
  task automatic test_glitch();
    int s;
    logic saw = 1'b0;
    evq.delete();
    s  = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = s; i < cyc; i++) saw |= busy_at[i];
    n_cmp++;
    if (saw !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy: got pulse=%b final=%b, required pulse=1 final=0", saw, busy);
    end
    n_cmp++;
    if (evq.size() !== 0 || rx_data !== last_good) begin
      n_bad++;
      $display("FAIL glitch_quiet: got strobes=%0d data=%h, required 0 strobes data=%h", evq.size(), rx_data, last_good);
    end
  endtask
  task automatic test_frame_err();
    ev_t e;
    evq.delete();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    e = pop_ev();
    n_cmp++;
    if (e.k !== K_FERR || e.c - t0 !== LAT || rx_data !== last_good) begin
      n_bad++;
      $display("FAIL frame_err: got kind=%0d lat=%0d data=%h, required kind=1 lat=%0d data=%h", e.k, e.c - t0, rx_data, LAT, last_good);
    end
    n_cmp++;
    if (evq.size() !== 0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL break_hold: got strobes=%0d busy=%b, required 0 strobes busy=1", evq.size(), busy);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL break_exit: got busy=%b, required 0", busy);
    end
    send_frame(8'h77, ^8'h77, 1'b1);
    repeat (2) @(negedge clk);
    e = pop_ev();
    n_cmp++;
    if (e.k !== K_VALID || e.d !== 8'h77 || e.c - t0 !== LAT) begin
      n_bad++;
      $display("FAIL after_break_77: got kind=%0d data=%h lat=%0d, required kind=0 data=77 lat=%0d", e.k, e.d, e.c - t0, LAT);
    end
    last_good = 8'h77;
  endtask
  task automatic test_back_to_back();
    ev_t e1, e2;
    int  ta;
    evq.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    ta = t0;
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    e1 = pop_ev();
    e2 = pop_ev();
    n_cmp++;
    if (e1.k !== K_VALID || e1.d !== 8'h00 || e1.c - ta !== LAT) begin
      n_bad++;
      $display("FAIL b2b_first: got kind=%0d data=%h lat=%0d, required kind=0 data=00 lat=%0d", e1.k, e1.d, e1.c - ta, LAT);
    end
    n_cmp++;
    if (e2.k !== K_VALID || e2.d !== 8'hFF || e2.c - e1.c !== FRAME) begin
      n_bad++;
      $display("FAIL b2b_second: got kind=%0d data=%h gap=%0d, required kind=0 data=ff gap=%0d", e2.k, e2.d, e2.c - e1.c, FRAME);
    end
    last_good = 8'hFF;
  endtask
  task automatic test_mid_reset();
    ev_t e;
    logic [7:0] d = 8'h5A;
    evq.delete();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, parity_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got data=%h v=%b fe=%b pe=%b busy=%b, required all 0",
               rx_data, rx_valid, frame_err, parity_err, busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (evq.size() !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_discard: got %0d strobes, required 0", evq.size());
    end
    send_frame(8'h11, ^8'h11, 1'b1);
    repeat (2) @(negedge clk);
    e = pop_ev();
    n_cmp++;
    if (e.k !== K_VALID || e.d !== 8'h11 || e.c - t0 !== LAT) begin
      n_bad++;
      $display("FAIL mid_reset_next_11: got kind=%0d data=%h lat=%0d, required kind=0 data=11 lat=%0d", e.k, e.d, e.c - t0, LAT);
    end
    last_good = 8'h11;
  endtask
  task automatic test_random();
    ev_t e;
    logic [7:0] d;
    logic p, s;
    int k;
    for (int n = 0; n < 14; n++) begin
      d = 8'($urandom);
      s = $urandom_range(0, 3) != 0;
      p = ^d ^ (PB == 1 && $urandom_range(0, 3) == 0);
      k = model_kind(d, p, s);
      evq.delete();
      send_frame(d, p, s);
      if (!s) begin
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end
      e = pop_ev();
      if (k == K_VALID) last_good = d;
      n_cmp++;
      if (e.k !== k || e.c - t0 !== LAT || rx_data !== last_good || evq.size() !== 0) begin
        n_bad++;
        $display("FAIL random_%0d: got kind=%0d lat=%0d data=%h extra=%0d, required kind=%0d lat=%0d data=%h extra=0",
                 n, e.k, e.c - t0, rx_data, evq.size(), k, LAT, last_good);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    ev_t e;
    evq.delete();
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    e = pop_ev();
    n_cmp++;
    if (e.k !== K_PERR || e.c - t0 !== LAT || rx_data !== last_good || evq.size() !== 0) begin
      n_bad++;
      $display("FAIL parity_bad: got kind=%0d lat=%0d data=%h, required kind=2 lat=%0d data=%h", e.k, e.c - t0, rx_data, LAT, last_good);
    end
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    e = pop_ev();
    n_cmp++;
    if (e.k !== K_VALID || e.d !== 8'h01 || e.c - t0 !== LAT) begin
      n_bad++;
      $display("FAIL parity_good: got kind=%0d data=%h lat=%0d, required kind=0 data=01 lat=%0d", e.k, e.d, e.c - t0, LAT);
    end
    last_good = 8'h01;
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
